ltl_report_collector: RTL and testbench
=======================================

// Module: ltl_report_collector
// PURPOSE
//  Consumes the report outputs of one LTL monitor automaton cluster (one bit per report STE).
//  Timestamps every symbol cycle on which a report fires and queues {timestamp, report vector}
//  records in a small FIFO. A valid/ready port drains the records to the monitor readout/CSR logic.
//  Also keeps a sticky hit flag, a saturating hit counter and overflow accounting.
// PARAMETERS
//  NUM_REPORTS       4   number of report inputs from the automaton
//  FIFO_DEPTH        8   record FIFO entries; power of two, >= 2
//  TS_WIDTH          16  timestamp width (symbol-cycle counter)
//  CNT_WIDTH         16  width of hit_count and drop_count
//  EDGE_MODE         0   0: record every cycle with any report bit set; 1: record only newly-rising bits
//  HALT_ON_OVERFLOW  0   1: stop capturing after the first dropped record, until clear
// PORTS
//  clk         in   1                     clock
//  reset       in   1                     synchronous, active-high reset
//  run         in   1                     symbol valid this cycle (same strobe that drives the automaton)
//  report_in   in   NUM_REPORTS           automaton report outputs, registered, bit i = report STE i
//  clear       in   1                     1-cycle pulse: flush FIFO, zero counters/flags/timestamp
//  rec_valid   out  1                     FIFO head valid
//  rec_ready   in   1                     consumer accepts head when rec_valid & rec_ready
//  rec_data    out  TS_WIDTH+NUM_REPORTS  {timestamp, report bits} of the head record
//  any_hit     out  1                     sticky: a record has been captured since reset/clear
//  hit_count   out  CNT_WIDTH             captured records (accepted or dropped), saturating
//  drop_count  out  CNT_WIDTH             records dropped because the FIFO was full, saturating
//  overflow    out  1                     sticky: drop_count != 0
//  halted      out  1                     1 while in the HALTED state
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, ts = 0, prev = 0, state ARMED.
//  Reset has priority over clear. Clear has the same effect as reset, except the FIFO contents
//  are discarded and the pop for that cycle is ignored.
//  Timestamp ts: increments by 1 (mod 2^TS_WIDTH) on every cycle with run=1. The record stores the
//  pre-increment value of ts.
//  hit vector: EDGE_MODE=0: hit = report_in. EDGE_MODE=1: hit = report_in & ~prev.
//  prev <= report_in only on cycles with run=1.
//  Capture event: state ARMED & run & (hit != 0). Report bits are ignored when run=0.
//  Capture actions:
//   - hit_count increments by 1.
//   - any_hit is set.
//   - Push {ts, hit} into the FIFO.
//  FIFO full on a capture cycle:
//   - Full with no pop in the same cycle: the record is dropped and drop_count increments.
//   - Full with a pop in the same cycle: the push is accepted and there is no drop.
//  FSM:
//   - ARMED -> HALTED on a drop when HALT_ON_OVERFLOW=1.
//   - HALTED -> ARMED only on clear or reset.
//   - HALTED: no captures and hit_count frozen; ts still counts; draining continues.
//  FIFO: first-word fall-through, registered storage.
//   - A pushed record appears on rec_data/rec_valid the cycle after the push.
//   - rec_data holds stable while rec_valid & !rec_ready.
//   - Pop occurs only when rec_valid & rec_ready; rec_ready while empty has no effect.
//   - Simultaneous push and pop on a non-empty FIFO: occupancy unchanged.
//   - Read and write pointers wrap modulo FIFO_DEPTH.
//  Counters saturate at 2^CNT_WIDTH-1 and do not wrap.
//  overflow asserts the cycle after the first drop.
//  halted and any_hit are registered and update one cycle after the triggering event.
// TESTING
//  1. EDGE_MODE=0, report_in=4'b0100 with run=1 at ts=5, rec_ready=1
//     -> next cycle rec_valid=1, rec_data={16'd5,4'b0100}, hit_count=1, any_hit=1.
//  2. EDGE_MODE=1, report_in=4'b0001 held for 3 run cycles, then 4'b0011
//     -> exactly 2 records, hit fields 4'b0001 then 4'b0010.
//  3. rec_ready=0, 10 consecutive hit cycles, DEPTH=8
//     -> 8 records queued, drop_count=2, overflow=1; then drain 8 records with ts values in order.
//  4. FIFO full, rec_ready=1 and a hit in the same cycle
//     -> no drop, occupancy stays 8, the new record is last out.
//  5. HALT_ON_OVERFLOW=1, overflow a full FIFO
//     -> halted=1; further hits are ignored and hit_count is frozen; clear -> all zero, state ARMED.
//  6. run=0 with report_in=4'hF for 4 cycles -> no records, ts unchanged.
//     Reset asserted with the FIFO non-empty -> rec_valid=0 next cycle.

Source files
------------

// File: rtl/ltl_report_collector.sv
// rtl/ltl_report_collector.sv - timestamps LTL monitor report hits and queues them in a FWFT FIFO
module ltl_report_collector #(
    parameter int NUM_REPORTS      = 4,
    parameter int FIFO_DEPTH       = 8,
    parameter int TS_WIDTH         = 16,
    parameter int CNT_WIDTH        = 16,
    parameter bit EDGE_MODE        = 1'b0,
    parameter bit HALT_ON_OVERFLOW = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            run,
    input  logic [NUM_REPORTS-1:0]          report_in,
    input  logic                            clear,
    output logic                            rec_valid,
    input  logic                            rec_ready,
    output logic [TS_WIDTH+NUM_REPORTS-1:0] rec_data,
    output logic                            any_hit,
    output logic [CNT_WIDTH-1:0]            hit_count,
    output logic [CNT_WIDTH-1:0]            drop_count,
    output logic                            overflow,
    output logic                            halted
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = TS_WIDTH + NUM_REPORTS;

    typedef enum logic {ARMED, HALTED} state_t;
    state_t state, state_next;

    logic [RW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [TS_WIDTH-1:0]    ts;
    logic [NUM_REPORTS-1:0] prev;
    logic [NUM_REPORTS-1:0] hit;
    logic                   capture, full, pop, push, drop;

    always_comb begin
        hit     = EDGE_MODE ? (report_in & ~prev) : report_in;
        capture = (state == ARMED) && run && (hit != '0);
        full    = (count == CW'(FIFO_DEPTH));
        pop     = rec_valid && rec_ready;
        // A full FIFO still accepts the push when the head leaves in the same cycle.
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    always_comb begin
        state_next = state;
        if (clear)
            state_next = ARMED;
        else if (state == ARMED && drop && HALT_ON_OVERFLOW)
            state_next = HALTED;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ARMED;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push && !reset && !clear)
            mem[wr_ptr] <= {ts, hit};
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ts         <= '0;
            prev       <= '0;
            any_hit    <= 1'b0;
            hit_count  <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (run) begin
                ts   <= ts + TS_WIDTH'(1);
                prev <= report_in;
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (capture) begin
                any_hit <= 1'b1;
                if (hit_count != '1)
                    hit_count <= hit_count + CNT_WIDTH'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + CNT_WIDTH'(1);
            end
        end
    end

    assign rec_valid = (count != '0);
    assign rec_data  = mem[rd_ptr];
    assign halted    = (state == HALTED);
endmodule

// File: tb/tb_ltl_report_collector.sv
// tb/tb_ltl_report_collector.sv - directed self-checking bench for ltl_report_collector
module tb_ltl_report_collector;
    logic        clk = 1'b0;
    logic        reset;

    logic        a_run, a_clear, a_rec_ready, a_rec_valid, a_any_hit, a_overflow, a_halted;
    logic [3:0]  a_report;
    logic [19:0] a_rec_data;
    logic [15:0] a_hit_count, a_drop_count;

    logic        b_run, b_clear, b_rec_ready, b_rec_valid, b_any_hit, b_overflow, b_halted;
    logic [3:0]  b_report;
    logic [19:0] b_rec_data;
    logic [15:0] b_hit_count, b_drop_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ltl_report_collector #(.EDGE_MODE(1'b0), .HALT_ON_OVERFLOW(1'b0)) u_a (
        .clk(clk), .reset(reset), .run(a_run), .report_in(a_report), .clear(a_clear),
        .rec_valid(a_rec_valid), .rec_ready(a_rec_ready), .rec_data(a_rec_data),
        .any_hit(a_any_hit), .hit_count(a_hit_count), .drop_count(a_drop_count),
        .overflow(a_overflow), .halted(a_halted)
    );

    ltl_report_collector #(.EDGE_MODE(1'b1), .HALT_ON_OVERFLOW(1'b1)) u_b (
        .clk(clk), .reset(reset), .run(b_run), .report_in(b_report), .clear(b_clear),
        .rec_valid(b_rec_valid), .rec_ready(b_rec_ready), .rec_data(b_rec_data),
        .any_hit(b_any_hit), .hit_count(b_hit_count), .drop_count(b_drop_count),
        .overflow(b_overflow), .halted(b_halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;
        a_run = 0; a_clear = 0; a_rec_ready = 0; a_report = 4'h0;
        b_run = 0; b_clear = 0; b_rec_ready = 0; b_report = 4'h0;
        step(); step();
        reset = 1'b0;

        chk("rst_valid", {31'd0, a_rec_valid}, 32'd0);
        chk("rst_hits", {16'd0, a_hit_count}, 32'd0);
        chk("rst_drops", {16'd0, a_drop_count}, 32'd0);
        chk("rst_flags", {29'd0, a_any_hit, a_overflow, a_halted}, 32'd0);

        // Test 1: advance ts to 5 with no hits, then one hit at ts=5.
        a_run = 1; a_report = 4'h0;
        repeat (5) step();
        a_report = 4'b0100; a_rec_ready = 1;
        step();
        a_run = 0; a_report = 4'h0;
        chk("t1_valid", {31'd0, a_rec_valid}, 32'd1);
        chk("t1_data", {12'd0, a_rec_data}, {12'd0, 16'd5, 4'b0100});
        chk("t1_hits", {16'd0, a_hit_count}, 32'd1);
        chk("t1_any", {31'd0, a_any_hit}, 32'd1);
        step();
        chk("t1_popped", {31'd0, a_rec_valid}, 32'd0);

        // Test 6a: report bits with run=0 are ignored and ts does not move (ts=6).
        a_rec_ready = 0; a_report = 4'hF;
        repeat (4) step();
        chk("t6_norec", {31'd0, a_rec_valid}, 32'd0);
        chk("t6_hits", {16'd0, a_hit_count}, 32'd1);
        a_run = 1; a_report = 4'b0001;
        step();
        a_run = 0; a_report = 4'h0;
        chk("t6_ts", {12'd0, a_rec_data}, {12'd0, 16'd6, 4'b0001});
        a_rec_ready = 1;
        step();
        chk("t6_empty", {31'd0, a_rec_valid}, 32'd0);

        // Test 3: 10 hits with rec_ready=0 (ts 7..16); 15 and 16 are dropped.
        a_rec_ready = 0; a_run = 1; a_report = 4'b0010;
        repeat (10) step();
        a_run = 0; a_report = 4'h0;
        chk("t3_drops", {16'd0, a_drop_count}, 32'd2);
        chk("t3_ovf", {31'd0, a_overflow}, 32'd1);
        chk("t3_hits", {16'd0, a_hit_count}, 32'd12);
        chk("t3_head", {12'd0, a_rec_data}, {12'd0, 16'd7, 4'b0010});

        // Test 4: full FIFO, pop and hit together at ts=17 -> no drop.
        a_rec_ready = 1; a_run = 1; a_report = 4'b1000;
        step();
        a_run = 0; a_report = 4'h0;
        chk("t4_drops", {16'd0, a_drop_count}, 32'd2);
        chk("t4_hits", {16'd0, a_hit_count}, 32'd13);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t3_drain%0d", i), {12'd0, a_rec_data},
                {12'd0, 16'(8 + i), 4'b0010});
            step();
        end
        chk("t4_last", {12'd0, a_rec_data}, {12'd0, 16'd17, 4'b1000});
        chk("t4_last_valid", {31'd0, a_rec_valid}, 32'd1);
        step();
        chk("t4_empty", {31'd0, a_rec_valid}, 32'd0);

        // Test 6b: reset with a non-empty FIFO.
        a_rec_ready = 0; a_run = 1; a_report = 4'b0001;
        step();
        a_run = 0; a_report = 4'h0;
        chk("t6_pre_rst", {31'd0, a_rec_valid}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_valid", {31'd0, a_rec_valid}, 32'd0);
        chk("t6_rst_hits", {16'd0, a_hit_count}, 32'd0);
        chk("t6_rst_ovf", {15'd0, a_overflow, a_drop_count}, 32'd0);

        // Test 2: edge mode, 0001 held 3 cycles (ts 0..2) then 0011 (ts 3).
        b_run = 1; b_report = 4'b0001;
        repeat (3) step();
        b_report = 4'b0011;
        step();
        b_run = 0;
        chk("t2_hits", {16'd0, b_hit_count}, 32'd2);
        chk("t2_rec0", {12'd0, b_rec_data}, {12'd0, 16'd0, 4'b0001});
        b_rec_ready = 1;
        step();
        chk("t2_rec1", {12'd0, b_rec_data}, {12'd0, 16'd3, 4'b0010});
        step();
        b_rec_ready = 0;
        chk("t2_empty", {31'd0, b_rec_valid}, 32'd0);

        // Test 5: halt on overflow; ts 4 no hit, ts 5..12 queued, ts 13 dropped.
        b_run = 1; b_report = 4'b0000;
        step();
        for (int i = 0; i < 9; i++) begin
            b_report = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            step();
        end
        chk("t5_halted", {31'd0, b_halted}, 32'd1);
        chk("t5_drops", {16'd0, b_drop_count}, 32'd1);
        chk("t5_ovf", {31'd0, b_overflow}, 32'd1);
        chk("t5_hits", {16'd0, b_hit_count}, 32'd11);
        for (int i = 0; i < 3; i++) begin
            b_report = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            step();
        end
        b_run = 0; b_report = 4'h0;
        chk("t5_frozen", {16'd0, b_hit_count}, 32'd11);
        chk("t5_nodrop", {16'd0, b_drop_count}, 32'd1);
        chk("t5_head", {12'd0, b_rec_data}, {12'd0, 16'd5, 4'b0001});
        b_rec_ready = 1;
        step();
        b_rec_ready = 0;
        chk("t5_drain", {12'd0, b_rec_data}, {12'd0, 16'd6, 4'b0010});
        b_clear = 1;
        step();
        b_clear = 0;
        chk("t5_clr_valid", {31'd0, b_rec_valid}, 32'd0);
        chk("t5_clr_cnts", {b_hit_count, b_drop_count}, 32'd0);
        chk("t5_clr_flags", {29'd0, b_any_hit, b_overflow, b_halted}, 32'd0);
        b_run = 1; b_report = 4'b0001;
        step();
        b_run = 0; b_report = 4'h0;
        chk("t5_rearm", {12'd0, b_rec_data}, {12'd0, 16'd0, 4'b0001});
        chk("t5_rearm_hits", {16'd0, b_hit_count}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
